// File: rtl/vdu_line_fetch_pkg.sv
// Shared definitions for the VDU line fetcher: display geometry, RGB332
// field layout, fetch FSM states and the RGB332 -> RGB888 expansion.
package vdu_pkg;

  localparam int VDU_H_ACTIVE = 640;
  localparam int VDU_V_ACTIVE = 480;

  // RGB332 field positions inside one pixel byte
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_ACK
  } fetch_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bit replication keeps full-scale codes at 0x00/0xFF and spreads the rest evenly.
  function automatic rgb_t rgb332_expand(input logic [7:0] px);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    rgb_t       o;
    r   = px[R_MSB:R_LSB];
    g   = px[G_MSB:G_LSB];
    b   = px[B_MSB:B_LSB];
    o.r = {r, r, r[2:1]};
    o.g = {g, g, g[2:1]};
    o.b = {b, b, b, b};
    return o;
  endfunction

endpackage

// File: rtl/vdu_line_fetch_fifo.sv
// vdu_fifo: small synchronous word FIFO between the memory fetcher and the
// pixel path. Flush has priority over push/pop; push on full and pop on
// empty are ignored.
module vdu_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] free
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign free    = CNT_W'(DEPTH) - count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array, no reset needed: contents are only read below count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdu_line_fetch.sv
// vdu_line_fetch: per-line pixel fetcher for the VGA output stage.
// Reads packed RGB332 pixel pairs over a single-outstanding req/ack bus into
// a small FIFO and emits one expanded RGB888 pixel per pixel_en strobe.
// Optional: VDU_LINE_FETCH_DOUBLE_SCAN_EN selects 320x240 mode (each byte
// shown on two strobes, each memory line shown on two display lines).
module vdu_line_fetch
  import vdu_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int H_ACTIVE   = VDU_H_ACTIVE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pixel_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              underrun
);

  // Words fetched per display line; also the memory stride between lines,
  // so a double-scan frame buffer is packed at 320 pixels per line.
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
  localparam int LINE_WORDS = H_ACTIVE / 4;
`else
  localparam int LINE_WORDS = H_ACTIVE / 2;
`endif
  localparam int WL_W  = $clog2(H_ACTIVE / 2 + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic              fetch_go, ack_take;
  logic [ADDR_W-1:0] line_addr;
  logic [WL_W-1:0]   words_left;

  logic [15:0]       fifo_dout;
  logic              fifo_empty, fifo_full, fifo_pop;
  logic [CNT_W-1:0]  fifo_free;

  logic              byte_sel;
  logic              last_rep;
  logic [7:0]        pix_byte;
  rgb_t              pix_q;

  vdu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (line_start),
    .push    (ack_take),
    .din     (mem_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .free    (fifo_free)
  );

  // Fetch FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Fetch FSM next state; line_start preempts whatever is in flight
  always_comb begin
    state_d  = state_q;
    fetch_go = 1'b0;
    ack_take = 1'b0;
    if (line_start) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (words_left == '0) begin
            state_d = IDLE;
          end else if (fifo_free != '0) begin
            fetch_go = 1'b1;
            state_d  = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            ack_take = 1'b1;
            state_d  = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Memory addressing: request/address registers and per-line bookkeeping
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
  logic line_par;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      words_left <= '0;
      line_addr  <= '0;
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
      line_par   <= 1'b0;
`endif
    end else begin
      if (line_start) begin
        mem_req    <= 1'b0;
        mem_addr   <= line_addr;
        words_left <= WL_W'(LINE_WORDS);
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
        // advance only after the second showing of a memory line
        line_par   <= ~line_par;
        if (line_par) line_addr <= line_addr + ADDR_W'(LINE_WORDS);
`else
        line_addr  <= line_addr + ADDR_W'(LINE_WORDS);
`endif
      end else begin
        if (fetch_go) mem_req <= 1'b1;
        if (ack_take) begin
          mem_req    <= 1'b0;
          mem_addr   <= mem_addr + ADDR_W'(1);
          words_left <= words_left - WL_W'(1);
        end
      end
      // frame_start only rebases; a fetch already running is left alone
      if (frame_start) begin
        line_addr <= base_addr;
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
        line_par  <= 1'b0;
`endif
      end
    end
  end

  // Pixel repeat counter: in double-scan each byte spans two strobes
`ifdef VDU_LINE_FETCH_DOUBLE_SCAN_EN
  logic rep_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     rep_q <= 1'b0;
    else if (line_start)              rep_q <= 1'b0;
    else if (pixel_en && !fifo_empty) rep_q <= ~rep_q;
  end
  assign last_rep = rep_q;
`else
  assign last_rep = 1'b1;
`endif

  assign pix_byte = byte_sel ? fifo_dout[15:8] : fifo_dout[7:0];
  assign fifo_pop = pixel_en && !fifo_empty && byte_sel && last_rep;

  // Pixel output register, byte select and sticky underrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q    <= '0;
      byte_sel <= 1'b0;
      underrun <= 1'b0;
    end else begin
      pix_q <= '0;
      if (frame_start) underrun <= 1'b0;
      if (pixel_en) begin
        if (fifo_empty) begin
          underrun <= 1'b1;
        end else begin
          pix_q <= rgb332_expand(pix_byte);
          if (last_rep) byte_sel <= ~byte_sel;
        end
      end
      if (line_start) byte_sel <= 1'b0;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

  // The FETCH guard must make pushing into a full FIFO impossible
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(ack_take && fifo_full));

endmodule
